// File: rtl/gelato_pkg.sv
// gelato_pkg: shared types and default sizes for the Gelato fetch front end.
`default_nettype none

package gelato_pkg;

  localparam int DEF_NUM_WARPS = 8;
  localparam int DEF_PC_WIDTH  = 32;

  typedef logic [$clog2(DEF_NUM_WARPS)-1:0] warp_num_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    WAIT  = 2'd2
  } warp_state_t;

endpackage

`default_nettype wire

// File: rtl/gelato_rr_arbiter.sv
// gelato_rr_arbiter: combinational round-robin pick of the first request at or after ptr.
`default_nettype none

module gelato_rr_arbiter #(
  parameter int NUM_REQ = 8,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  logic [IW-1:0] cand;

  always_comb begin
    cand  = ptr;
    idx   = ptr;
    valid = 1'b0;
    gnt   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'((int'(ptr) + i) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    if (valid) gnt[idx] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/gelato_warp_scheduler.sv
// gelato_warp_scheduler: per-warp PC/state owner and round-robin fetch request generator.
// Optional stall_cycles counter is built when GELATO_SCHED_PERF_EN is defined.
`default_nettype none

module gelato_warp_scheduler
  import gelato_pkg::*;
#(
  parameter int NUM_WARPS = DEF_NUM_WARPS,
  parameter int PC_WIDTH  = DEF_PC_WIDTH,
  parameter int PC_STEP   = 4,
  localparam int WW = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 launch_valid,
  input  logic [WW-1:0]        launch_warp,
  input  logic [PC_WIDTH-1:0]  launch_pc,
  input  logic                 exit_valid,
  input  logic [WW-1:0]        exit_warp,
  input  logic                 redirect_valid,
  input  logic [WW-1:0]        redirect_warp,
  input  logic [PC_WIDTH-1:0]  redirect_pc,
  input  logic                 done_valid,
  input  logic [WW-1:0]        done_warp,
  input  logic [NUM_WARPS-1:0] ibuf_full,
  input  logic                 fetch_ready,
  output logic                 fetch_valid,
  output logic [PC_WIDTH-1:0]  fetch_pc,
  output logic [WW-1:0]        fetch_warp_num,
  output logic [NUM_WARPS-1:0] active_mask
`ifdef GELATO_SCHED_PERF_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  warp_state_t          state_q [NUM_WARPS];
  warp_state_t          state_d [NUM_WARPS];
  logic [PC_WIDTH-1:0]  pc_q    [NUM_WARPS];
  logic [PC_WIDTH-1:0]  pc_d    [NUM_WARPS];
  logic [WW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 fetch_valid_q, fetch_valid_d;
  logic [PC_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [WW-1:0]        fetch_warp_q, fetch_warp_d;
  logic [NUM_WARPS-1:0] active_mask_q, active_mask_d;

  logic [NUM_WARPS-1:0] elig;
  logic [NUM_WARPS-1:0] gnt;
  logic [WW-1:0]        gnt_idx;
  logic                 gnt_valid;
  logic                 accept;
  logic [PC_WIDTH-1:0]  gnt_pc;

  assign accept = fetch_valid_q && fetch_ready;

  // The presented warp is excluded even when it is being accepted this cycle,
  // since its state/pc only advance at the coming edge.
  always_comb begin
    elig = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      elig[w] = (state_q[w] == READY) && !ibuf_full[w] &&
                !(fetch_valid_q && (fetch_warp_q == WW'(w)));
    end
  end

  gelato_rr_arbiter #(.NUM_REQ(NUM_WARPS)) u_arb (
    .req   (elig),
    .ptr   (rr_ptr_q),
    .gnt   (gnt),
    .idx   (gnt_idx),
    .valid (gnt_valid)
  );

  always_comb begin
    gnt_pc = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (gnt[w]) gnt_pc = pc_q[w];
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    rr_ptr_d      = rr_ptr_q;
    fetch_valid_d = fetch_valid_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_warp_d  = fetch_warp_q;
    active_mask_d = active_mask_q;
    if (rdy) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (exit_valid && (exit_warp == WW'(w))) begin
          state_d[w] = IDLE;
        end else if (launch_valid && (launch_warp == WW'(w)) && (state_q[w] == IDLE)) begin
          state_d[w] = READY;
        end else if (done_valid && (done_warp == WW'(w)) && (state_q[w] == WAIT)) begin
          state_d[w] = READY;
        end else if (accept && (fetch_warp_q == WW'(w)) && (state_q[w] == READY)) begin
          state_d[w] = WAIT;
        end

        if (launch_valid && (launch_warp == WW'(w)) && (state_q[w] == IDLE) &&
            !(exit_valid && (exit_warp == WW'(w)))) begin
          pc_d[w] = launch_pc;
        end else if (redirect_valid && (redirect_warp == WW'(w))) begin
          pc_d[w] = redirect_pc;
        end else if (accept && (fetch_warp_q == WW'(w)) && (state_q[w] == READY)) begin
          pc_d[w] = pc_q[w] + PC_WIDTH'(PC_STEP);
        end

        active_mask_d[w] = (state_d[w] != IDLE);
      end

      if (!fetch_valid_q || accept) begin
        fetch_valid_d = gnt_valid;
        if (gnt_valid) begin
          fetch_pc_d   = gnt_pc;
          fetch_warp_d = gnt_idx;
          rr_ptr_d     = gnt_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_q[w] <= IDLE;
        pc_q[w]    <= '0;
      end
      rr_ptr_q      <= '0;
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= '0;
      fetch_warp_q  <= '0;
      active_mask_q <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_q[w] <= state_d[w];
        pc_q[w]    <= pc_d[w];
      end
      rr_ptr_q      <= rr_ptr_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_warp_q  <= fetch_warp_d;
      active_mask_q <= active_mask_d;
    end
  end

  assign fetch_valid    = fetch_valid_q;
  assign fetch_pc       = fetch_pc_q;
  assign fetch_warp_num = fetch_warp_q;
  assign active_mask    = active_mask_q;

`ifdef GELATO_SCHED_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (rdy && (|active_mask_q) && !fetch_valid_q && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

`default_nettype wire

// File: doc/gelato_warp_scheduler.md
Name: gelato_warp_scheduler

Overview:
- Fetch-side warp scheduler. Chooses which warp issues the next instruction fetch, owns each warp's PC, and tracks one outstanding fetch per warp.
- Sits ahead of the ifetch stage. Its fetch request carries pc and warp_num, which flow through ifetch and instruction decode into the ibuffer.
- Takes ibuffer back-pressure, decode-complete, branch redirect and warp launch/exit events. Sequences warps round-robin.

Parameters:
- NUM_WARPS, 8, number of hardware warp slots (power of two, at least 2)
- PC_WIDTH, 32, program counter width
- PC_STEP, 4, byte increment applied to the PC after each accepted fetch

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; when low, all state is frozen
- launch_valid  in  1  start a warp
- launch_warp  in  $clog2(NUM_WARPS)  slot to start
- launch_pc  in  PC_WIDTH  start PC
- exit_valid  in  1  retire a warp
- exit_warp  in  $clog2(NUM_WARPS)  slot to retire
- redirect_valid  in  1  branch/jump PC override
- redirect_warp  in  $clog2(NUM_WARPS)  target slot
- redirect_pc  in  PC_WIDTH  new PC
- done_valid  in  1  decode finished this warp's fetch
- done_warp  in  $clog2(NUM_WARPS)  warp completed
- ibuf_full  in  NUM_WARPS  per-warp ibuffer full
- fetch_ready  in  1  ifetch accepts request
- fetch_valid  out  1  request valid (registered)
- fetch_pc  out  PC_WIDTH  request PC (registered)
- fetch_warp_num  out  $clog2(NUM_WARPS)  request warp (registered)
- active_mask  out  NUM_WARPS  slots not IDLE

Behaviour:
- Per-warp state: IDLE, READY, WAIT. Per-warp registers: pc, plus a round-robin pointer rr_ptr.
- Reset: all warps IDLE, all pc 0, rr_ptr 0. Outputs reset as fetch_valid=0, fetch_pc=0, fetch_warp_num=0, active_mask=0.
- rdy=0: no register changes. Outputs hold their current values.
- IDLE -> READY: on launch_valid for that slot; pc <= launch_pc. A launch aimed at a non-IDLE slot is ignored.
- Eligibility: a warp is eligible when state==READY, ibuf_full[w]==0, and it is not the warp currently presented on an un-accepted request.
- Grant: when fetch_valid==0, or when (fetch_valid && fetch_ready) in the same cycle, pick the first eligible warp at or after rr_ptr (wrapping).
  - The grant registers fetch_valid=1, fetch_pc=pc[w] and fetch_warp_num=w on the next edge.
  - rr_ptr <= w+1, modulo NUM_WARPS.
  - If no warp is eligible, fetch_valid <= 0.
- Back-to-back issue: a new request may present in the cycle after acceptance. Sustained throughput is 1 request/cycle across distinct warps.
- Acceptance (fetch_valid && fetch_ready): the presented warp goes READY -> WAIT and its pc <= pc + PC_STEP, truncated to PC_WIDTH (wraps).
- Stability: while fetch_valid && !fetch_ready, fetch_pc and fetch_warp_num are held unchanged.
- WAIT -> READY: on done_valid with done_warp==w. A done for a warp not in WAIT is ignored.
- Redirect: pc[w] <= redirect_pc; state is unchanged. Redirect has priority over the acceptance increment in the same cycle.
- Exit: state -> IDLE regardless of current state. If the exiting warp is currently presented, the request stays valid until accepted; acceptance then does not leave the slot IDLE->WAIT.
- Same-cycle priority per slot: exit > launch > redirect > done > acceptance.
- Events on different slots in the same cycle all apply independently.
- Asynchronous reset mid-request drops fetch_valid immediately.

Optional Feature:
- Macro: GELATO_SCHED_PERF_EN.
- Defined: adds output stall_cycles (32 bits). It increments each rdy cycle with active_mask!=0 and fetch_valid==0. It saturates at all-ones and resets to 0.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- gelato_pkg gains:
  - warp_state_t enum {IDLE, READY, WAIT}
  - NUM_WARPS and PC_WIDTH defaults
  - the warp_num_t typedef
- Sub-module gelato_rr_arbiter (NUM_REQ parameter): eligible vector plus pointer in, one-hot grant and index out. Purely combinational; reused later by the issue stage.

Test Plan:
- Launch warp 0 @0x100, hold fetch_ready=1 -> request (w0, 0x100) next cycle; after done_valid(w0), request (w0, 0x104).
- Launch w0 @0x0, w1 @0x1000, w2 @0x2000, done returned promptly -> grants rotate w0, w1, w2, w0, with each PC advanced by 4.
- fetch_ready=0 for 5 cycles while w1 is presented and w2 is READY -> pc/warp held stable; w2 issued only after acceptance.
- ibuf_full[1]=1 with w0 and w1 READY -> only w0 is granted; deasserting the flag restores w1 on the next grant.
- Redirect w0 to 0x800 in the same cycle w0 is accepted at 0x100 -> pc[w0]=0x800, not 0x104; next w0 request is 0x800.
- Exit w3 while it is presented, then accept -> active_mask[3]=0 and no further w3 requests. Reset asserted mid-stream -> fetch_valid=0 at once and all PCs 0.
